// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front end.
package ifetch_pkg;

  typedef logic [31:0] addr;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    addr    pc;
    instr_t instr;
  } fetch_bundle;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

  localparam addr RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through FIFO with registered storage and synchronous clear.
// Used both as the pc queue for in-flight requests and as the output buffer.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; clear wins over any push or pop.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop) begin
        rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      end
      if (do_push) begin
        wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !clr_i && full_o && !pop_i));
`endif

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: issues sequential reads, pairs returned words
// with their pc and streams them to decode, squashing wrong-path fetches on redirect.
module ifetch
  import ifetch_pkg::*;
#(
  parameter addr RESET_PC = RESET_PC_DEFAULT,
  parameter int  DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redir_valid,
  input  logic [31:0] redir_target
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  addr           fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          req_fire, resp_keep, out_fire;
  addr           redir_pc;
  addr           pcq_head;
  logic          pcq_empty, pcq_full;
  logic [CW-1:0] pcq_cnt;
  fetch_bundle   push_bundle, out_head;
  logic          outq_empty, outq_full;
  logic [CW-1:0] outq_cnt;

  assign redir_pc    = redir_target & 32'hFFFF_FFFC;
  assign push_bundle = '{pc: pcq_head, instr: resp_data};
  assign out_valid   = !outq_empty;
  assign out_fire    = out_valid && out_ready;
  assign req_addr    = fetch_pc_q;
  assign out_pc      = out_valid ? out_head.pc : '0;
  assign out_instr   = out_valid ? out_head.instr : '0;

  // Request credit, counter updates and state transitions; redirect overrides all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    req_valid  = (state_q != BOOT) && ((int'(outst_q) + int'(outq_cnt)) < DEPTH);
    req_fire   = req_valid && req_ready;
    resp_keep  = resp_valid && (drop_q == '0) && !redir_valid;

    case ({req_fire, resp_valid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = (drop_d == '0) ? RUN : FLUSH;
      default: state_d = BOOT;
    endcase

    if (redir_valid) begin
      fetch_pc_d = redir_pc;
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? FLUSH : RUN;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redir_valid),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (resp_valid && (drop_q == '0)),
    .data_o  (pcq_head),
    .empty_o (pcq_empty),
    .full_o  (pcq_full),
    .count_o (pcq_cnt)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_bundle))
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redir_valid),
    .push_i  (resp_keep),
    .data_i  (push_bundle),
    .pop_i   (out_fire),
    .data_o  (out_head),
    .empty_o (outq_empty),
    .full_o  (outq_full),
    .count_o (outq_cnt)
  );

`ifndef SYNTHESIS
  a_outst_cap:  assert property (@(posedge clk) disable iff (!rst) int'(outst_q) <= DEPTH);
  a_drop_cap:   assert property (@(posedge clk) disable iff (!rst) drop_q <= outst_q);
  a_out_ovf:    assert property (@(posedge clk) disable iff (!rst)
    !(resp_keep && outq_full && !out_fire));
  a_pcq_ovf:    assert property (@(posedge clk) disable iff (!rst) !(req_fire && pcq_full));
  a_pcq_under:  assert property (@(posedge clk) disable iff (!rst) !(resp_keep && pcq_empty));
  a_pcq_track:  assert property (@(posedge clk) disable iff (!rst) pcq_cnt <= outst_q);
`endif

endmodule

// File: tb/tb_ifetch.sv
// Randomised self-checking bench for ifetch with a transaction-level memory
// and fetch-stream reference model.
module tb_ifetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        redir_valid;
  logic [31:0] redir_target;

  ifetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          ep;
    int          due;
  } memEntry_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
  } word_t;

  memEntry_t   memQ[$];
  word_t       bufQ[$];
  int          epoch = 0;
  int          cyc = 0;
  int          lastDue = 0;
  logic [31:0] reqExp = RST_PC;
  logic [31:0] seqPc = RST_PC;
  bit          boot = 1'b1;

  int          checks = 0;
  int          failures = 0;

  int          latMin = 1, latMax = 1;
  int          pReqReady = 100, pOutReady = 100, pRedir = 0;
  bit          forceRedir = 1'b0;
  bit          redirOnCollide = 1'b0;
  logic [31:0] forceTgt = '0;
  bit          sawZero = 1'b0;
  bit          lastOv = 1'b0;
  int          pops = 0;
  int          hsCount = 0;
  logic [31:0] lastPopPc = '0;

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle();
    bit          rvExp, respNow, hs, pop;
    logic [31:0] tgt;
    memEntry_t   e;
    word_t       w;
    int          due;
    req_ready  = ($urandom_range(99) < pReqReady);
    out_ready  = ($urandom_range(99) < pOutReady);
    respNow    = (memQ.size() > 0) && (memQ[0].due <= cyc);
    resp_valid = respNow;
    resp_data  = respNow ? memQ[0].d : $urandom;
    rvExp      = !boot && ((memQ.size() + bufQ.size()) < DEPTH);
    redir_valid = 1'b0;
    tgt = $urandom;
    if (forceRedir) begin
      redir_valid = 1'b1;
      tgt = forceTgt;
      forceRedir = 1'b0;
    end else if (redirOnCollide && rvExp && req_ready && respNow) begin
      redir_valid = 1'b1;
      tgt = forceTgt;
      redirOnCollide = 1'b0;
    end else if ($urandom_range(99) < pRedir) begin
      redir_valid = 1'b1;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    end
    redir_target = tgt;
    #3;
    lastOv = out_valid;
    checks++;
    if (req_valid !== rvExp) begin
      failures++;
      $display("[TB] FAIL req_valid cyc=%0d: got %b expected %b", cyc, req_valid, rvExp);
    end
    if (rvExp) begin
      checks++;
      if (req_addr !== reqExp) begin
        failures++;
        $display("[TB] FAIL req_addr cyc=%0d: got %h expected %h", cyc, req_addr, reqExp);
      end
    end
    checks++;
    if (out_valid !== (bufQ.size() != 0)) begin
      failures++;
      $display("[TB] FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, bufQ.size() != 0);
    end
    if (bufQ.size() != 0) begin
      checks++;
      if (out_pc !== bufQ[0].pc || out_instr !== bufQ[0].d) begin
        failures++;
        $display("[TB] FAIL out_word cyc=%0d: got %h/%h expected %h/%h",
                 cyc, out_pc, out_instr, bufQ[0].pc, bufQ[0].d);
      end
    end
    hs  = rvExp && req_ready;
    pop = (bufQ.size() != 0) && out_ready;
    if (pop) begin
      checks++;
      if (out_pc !== seqPc) begin
        failures++;
        $display("[TB] FAIL program_order cyc=%0d: got %h expected %h", cyc, out_pc, seqPc);
      end
      lastPopPc = out_pc;
      pops++;
      seqPc = seqPc + 32'd4;
      void'(bufQ.pop_front());
    end
    if (respNow) begin
      e = memQ.pop_front();
      if (e.ep == epoch && !redir_valid) begin
        w.pc = e.a;
        w.d  = e.d;
        bufQ.push_back(w);
      end
    end
    if (hs) begin
      due = cyc + $urandom_range(latMax, latMin);
      if (due <= lastDue) due = lastDue + 1;
      e.a = reqExp; e.d = $urandom; e.ep = epoch; e.due = due;
      memQ.push_back(e);
      lastDue = due;
      hsCount++;
      if (reqExp == 32'h0) sawZero = 1'b1;
      reqExp = reqExp + 32'd4;
    end
    if (redir_valid) begin
      bufQ.delete();
      epoch++;
      reqExp = {tgt[31:2], 2'b00};
      seqPc  = {tgt[31:2], 2'b00};
    end
    boot = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges, then release away from the clock edge.
  task automatic do_reset();
    rst = 1'b0;
    req_ready = 1'b0; out_ready = 1'b0; resp_valid = 1'b0;
    resp_data = '0; redir_valid = 1'b0; redir_target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    memQ.delete();
    bufQ.delete();
    epoch++;
    reqExp = RST_PC;
    seqPc = RST_PC;
    boot = 1'b1;
    lastDue = cyc;
    pops = 0;
    hsCount = 0;
  endtask

  task automatic run_until_pop(input int budget, input string name, input logic [31:0] expPc);
    int start = pops;
    for (int i = 0; i < budget && pops == start; i++) cycle();
    checks++;
    if (pops == start) begin
      failures++;
      $display("[TB] FAIL %s: no output within %0d cycles, expected pc %h", name, budget, expPc);
    end else if (lastPopPc !== expPc) begin
      failures++;
      $display("[TB] FAIL %s: got pc %h expected %h", name, lastPopPc, expPc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_ready = 1'b1; out_ready = 1'b1; resp_valid = 1'b0;
    resp_data = '0; redir_valid = 1'b0; redir_target = '0;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({req_valid, out_valid} !== 2'b00 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got rv=%b ov=%b pc=%h instr=%h expected all zero",
                 req_valid, out_valid, out_pc, out_instr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sequential();
    int first = -1;
    $display("[TB] sequential fetch, latency 1");
    do_reset();
    latMin = 1; latMax = 1; pReqReady = 100; pOutReady = 100; pRedir = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (lastOv && first < 0) first = i;
    end
    checks++;
    if (first != 3) begin
      failures++;
      $display("[TB] FAIL first_out_latency: got %0d expected 3", first);
    end
  endtask

  task automatic test_backpressure();
    $display("[TB] decode stalled for 10 cycles");
    do_reset();
    latMin = 1; latMax = 1; pReqReady = 100; pOutReady = 0; pRedir = 0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (hsCount != 2 || req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL credit_stall: got %0d requests rv=%b expected 2 requests rv=0",
               hsCount, req_valid);
    end
    pOutReady = 100;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (pops < 6) begin
      failures++;
      $display("[TB] FAIL stall_resume: got %0d outputs expected at least 6", pops);
    end
  endtask

  task automatic test_redirect_flush();
    $display("[TB] redirect with two requests outstanding, latency 3");
    do_reset();
    latMin = 3; latMax = 3; pReqReady = 100; pOutReady = 100; pRedir = 0;
    for (int i = 0; i < 20 && memQ.size() != 2; i++) cycle();
    checks++;
    if (memQ.size() != 2) begin
      failures++;
      $display("[TB] FAIL flush_setup: got %0d outstanding expected 2", memQ.size());
    end
    forceRedir = 1'b1;
    forceTgt = 32'h8000_0102;
    cycle();
    run_until_pop(30, "flush_first_pc", 32'h8000_0100);
  endtask

  task automatic test_back_to_back();
    $display("[TB] redirect colliding with handshake and response");
    do_reset();
    latMin = 1; latMax = 1; pReqReady = 100; pOutReady = 100; pRedir = 0;
    forceTgt = 32'h0000_1000;
    redirOnCollide = 1'b1;
    for (int i = 0; i < 12 && redirOnCollide; i++) cycle();
    checks++;
    if (redirOnCollide) begin
      failures++;
      $display("[TB] FAIL collide_setup: got no collision cycle expected one");
      redirOnCollide = 1'b0;
    end
    run_until_pop(20, "collide_first_pc", 32'h0000_1000);
  endtask

  task automatic test_wrap();
    $display("[TB] address wrap");
    latMin = 1; latMax = 2; pReqReady = 100; pOutReady = 100; pRedir = 0;
    sawZero = 1'b0;
    forceRedir = 1'b1;
    forceTgt = 32'hFFFF_FFF6;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (!sawZero) begin
      failures++;
      $display("[TB] FAIL wrap_addr: got no request at 00000000 expected one");
    end
  endtask

  task automatic test_random();
    $display("[TB] randomised traffic");
    latMin = 1; latMax = 4; pReqReady = 70; pOutReady = 60; pRedir = 6;
    for (int i = 0; i < 500; i++) cycle();
    pRedir = 0;
  endtask

  task automatic test_async_reset();
    $display("[TB] asynchronous reset mid-stream");
    latMin = 1; latMax = 1; pReqReady = 100; pOutReady = 0; pRedir = 0;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (out_valid !== (bufQ.size() != 0) || bufQ.size() != DEPTH) begin
      failures++;
      $display("[TB] FAIL prefill: got ov=%b buffered=%0d expected ov=1 buffered=%0d",
               out_valid, bufQ.size(), DEPTH);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: got rv=%b ov=%b expected 0/0", req_valid, out_valid);
    end
    do_reset();
    pOutReady = 100;
    run_until_pop(20, "restart_pc", RST_PC);
    for (int i = 0; i < 10; i++) cycle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_back_to_back();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
